// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order pipeline: tracks DEPTH post-decode slots,
// selects EX operand forwarding and inserts load-use stall bubbles.

module pipe_hazard_slot_match #(
    parameter int ADDR_W = 5
) (
    input  logic              valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    output logic              id_rs_hit,
    output logic              id_rt_hit,
    output logic              ex_rs_hit,
    output logic              ex_rt_hit
);
    // r0 is hardwired, so a write to it never produces a value
    logic live;
    assign live      = valid & wr_en & (wr_addr != '0);
    assign id_rs_hit = live & (wr_addr == id_rs);
    assign id_rt_hit = live & (wr_addr == id_rt);
    assign ex_rs_hit = live & (wr_addr == ex_rs);
    assign ex_rt_hit = live & (wr_addr == ex_rt);
endmodule

module pipe_hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 3,
    parameter int FWD_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [ADDR_W-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              bubble,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);
    typedef struct packed {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic              is_load;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } slot_t;

    logic [DEPTH:1] vld_pipe;
    slot_t          slot_q [1:DEPTH];
    slot_t          id_slot;
    logic [DEPTH:1] id_rs_hit, id_rt_hit, ex_rs_hit, ex_rt_hit;
    logic           stall;
    logic           unused_bits;

    genvar g;
    generate
        for (g = 1; g <= DEPTH; g++) begin : g_slot
            pipe_hazard_slot_match #(.ADDR_W(ADDR_W)) u_match (
                .valid     (vld_pipe[g]),
                .wr_en     (slot_q[g].wr_en),
                .wr_addr   (slot_q[g].wr_addr),
                .id_rs     (id_rs),
                .id_rt     (id_rt),
                .ex_rs     (slot_q[1].rs),
                .ex_rt     (slot_q[1].rt),
                .id_rs_hit (id_rs_hit[g]),
                .id_rt_hit (id_rt_hit[g]),
                .ex_rs_hit (ex_rs_hit[g]),
                .ex_rt_hit (ex_rt_hit[g])
            );
        end
    endgenerate

    assign id_slot = '{wr_en: id_wr_en, wr_addr: id_wr_addr, is_load: id_is_load,
                       rs: id_rs, rt: id_rt, rs_used: id_rs_used, rt_used: id_rt_used};

    // A load in slot k reaches slot k+1 when the consumer reaches EX; stall
    // until that slot is at or past the load-ready point.
    always_comb begin
        stall = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (k + 1 < LOAD_RDY && slot_q[k].is_load &&
                ((id_rs_used && id_rs_hit[k]) || (id_rt_used && id_rt_hit[k])))
                stall = 1'b1;
        end
        stall = stall & id_valid;
    end

    // Descending scan so the youngest eligible producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (ex_rs_hit[k] && (!slot_q[k].is_load || k >= LOAD_RDY))
                fwd_a = FWD_W'(k - 1);
            if (ex_rt_hit[k] && (!slot_q[k].is_load || k >= LOAD_RDY))
                fwd_b = FWD_W'(k - 1);
        end
        if (!(vld_pipe[1] && slot_q[1].rs_used)) fwd_a = '0;
        if (!(vld_pipe[1] && slot_q[1].rt_used)) fwd_b = '0;
    end

    assign pc_write    = ~(stall | hold);
    assign if_id_write = ~(stall | hold);
    assign bubble      = stall & ~hold;
    assign if_id_flush = branch_taken & id_valid & ~stall & ~hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            for (int k = 1; k <= DEPTH; k++) slot_q[k] <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold) begin
            vld_pipe  <= {vld_pipe[DEPTH-1:1], id_valid & ~stall};
            for (int k = DEPTH; k >= 2; k--) slot_q[k] <= slot_q[k-1];
            slot_q[1] <= id_slot;
            if (bubble && stall_cnt != 16'hFFFF)      stall_cnt <= stall_cnt + 16'd1;
            if (if_id_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    // Source fields of older slots and edge-slot hits are kept but never consulted.
    always_comb begin
        unused_bits = ex_rs_hit[1] ^ ex_rt_hit[1] ^ id_rs_hit[DEPTH] ^ id_rt_hit[DEPTH];
        for (int k = 2; k <= DEPTH; k++)
            unused_bits = unused_bits ^ (^{slot_q[k].rs, slot_q[k].rt,
                                           slot_q[k].rs_used, slot_q[k].rt_used});
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default instance and a DEPTH=5/LOAD_RDY=4
// instance share stimulus and are each compared against an instruction-table model.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       hold = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_wr_addr = '0;
    logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_wr_en = 1'b0;
    logic       id_is_load = 1'b0, branch_taken = 1'b0;

    logic        pcw0, ifw0, fl0, bb0, pcw1, ifw1, fl1, bb1;
    logic [1:0]  fa0, fb0;
    logic [2:0]  fa1, fb1;
    logic [15:0] sc0, fc0, sc1, fc1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u0 (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .pc_write(pcw0), .if_id_write(ifw0),
        .if_id_flush(fl0), .bubble(bb0), .fwd_a(fa0), .fwd_b(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_hazard_ctrl #(.ADDR_W(5), .DEPTH(5), .LOAD_RDY(4), .FWD_W(3)) u1 (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .pc_write(pcw1), .if_id_write(ifw1),
        .if_id_flush(fl1), .bubble(bb1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    // Instruction record per in-flight pipeline position.
    typedef struct {
        bit valid, wr_en, is_load, rs_used, rt_used;
        int wr_addr, rs, rt;
    } ins_t;

    ins_t tab [2][1:7];
    ins_t nil;
    int   dep [2] = '{3, 5};
    int   lr  [2] = '{3, 4};
    int   scnt [2];
    int   fcnt [2];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic bit produces(input int c, input int k, input int a);
        return tab[c][k].valid && tab[c][k].wr_en && tab[c][k].wr_addr == a && a != 0;
    endfunction

    function automatic bit exp_stall(input int c);
        bit s = 1'b0;
        if (!id_valid) return 1'b0;
        for (int k = 1; k < dep[c]; k++)
            if (tab[c][k].is_load && k + 1 < lr[c] &&
                ((id_rs_used && produces(c, k, int'(id_rs))) ||
                 (id_rt_used && produces(c, k, int'(id_rt)))))
                s = 1'b1;
        return s;
    endfunction

    function automatic int exp_fwd(input int c, input bit use_rt);
        int a;
        bit u;
        a = use_rt ? tab[c][1].rt : tab[c][1].rs;
        u = use_rt ? tab[c][1].rt_used : tab[c][1].rs_used;
        if (!(tab[c][1].valid && u)) return 0;
        for (int k = 2; k <= dep[c]; k++)
            if (produces(c, k, a) && (!tab[c][k].is_load || k >= lr[c])) return k - 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cfg%0d: observed %0d expected %0d", tag, c, obs, exp);
        end
    endtask

    task automatic chk_cfg(input int c, input logic pw, input logic iw, input logic fl, input logic bb,
                           input logic [31:0] fa, input logic [31:0] fb,
                           input logic [31:0] sc, input logic [31:0] fcn);
        bit st;
        st = exp_stall(c);
        chk("pc_write",    c, 32'(pw), 32'(!(st || hold)));
        chk("if_id_write", c, 32'(iw), 32'(!(st || hold)));
        chk("if_id_flush", c, 32'(fl), 32'(branch_taken && id_valid && !st && !hold));
        chk("bubble",      c, 32'(bb), 32'(st && !hold));
        chk("fwd_a",       c, fa, exp_fwd(c, 1'b0));
        chk("fwd_b",       c, fb, exp_fwd(c, 1'b1));
        chk("stall_cnt",   c, sc, scnt[c]);
        chk("flush_cnt",   c, fcn, fcnt[c]);
    endtask

    task automatic check_all();
        chk_cfg(0, pcw0, ifw0, fl0, bb0, 32'(fa0), 32'(fb0), 32'(sc0), 32'(fc0));
        chk_cfg(1, pcw1, ifw1, fl1, bb1, 32'(fa1), 32'(fb1), 32'(sc1), 32'(fc1));
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int k = 1; k <= 7; k++) tab[c][k] = nil;
            scnt[c] = 0;
            fcnt[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            bit st;
            st = exp_stall(c);
            if (!hold) begin
                if (st && scnt[c] < 65535) scnt[c]++;
                if (branch_taken && id_valid && !st && fcnt[c] < 65535) fcnt[c]++;
                for (int k = dep[c]; k >= 2; k--) tab[c][k] = tab[c][k-1];
                tab[c][1].valid   = id_valid && !st;
                tab[c][1].wr_en   = id_wr_en;
                tab[c][1].wr_addr = int'(id_wr_addr);
                tab[c][1].is_load = id_is_load;
                tab[c][1].rs      = int'(id_rs);
                tab[c][1].rt      = int'(id_rt);
                tab[c][1].rs_used = id_rs_used;
                tab[c][1].rt_used = id_rt_used;
            end
        end
    endtask

    task automatic issue(input int rs, input int rt, input bit rsu, input bit rtu,
                         input bit we, input int wa, input bit ld, input bit br);
        id_valid = 1'b1; id_rs = 5'(rs); id_rt = 5'(rt);
        id_rs_used = rsu; id_rt_used = rtu; id_wr_en = we; id_wr_addr = 5'(wa);
        id_is_load = ld; branch_taken = br; hold = 1'b0;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_wr_en = 1'b0; id_wr_addr = '0; id_is_load = 1'b0; branch_taken = 1'b0; hold = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        nop();
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        do_reset();
        settle();
        chk("rst_pc_write", 0, 32'(pcw0), 1);
        chk("rst_bubble",   0, 32'(bb0), 0);
        chk("rst_fwd_a",    1, 32'(fa1), 0);
        chk("rst_stall_cnt", 1, 32'(sc1), 0);
        tick();

        // ALU producer r5, two consumers: forward distance 1 then 2
        do_reset();
        issue(1, 2, 0, 0, 1, 5, 0, 0);  settle(); tick();
        issue(5, 0, 1, 0, 1, 10, 0, 0); settle(); chk("alu_no_stall", 0, 32'(bb0), 0); tick();
        issue(5, 0, 1, 0, 1, 11, 0, 0); settle(); chk("alu_fwd1", 0, 32'(fa0), 1); tick();
        nop();                          settle(); chk("alu_fwd2", 0, 32'(fa0), 2); tick();

        // Load-use on rt: one bubble then forward from slot 3
        do_reset();
        issue(0, 0, 0, 0, 1, 8, 1, 0);  settle(); tick();
        issue(0, 8, 0, 1, 0, 0, 0, 0);  settle();
        chk("lu_bubble", 0, 32'(bb0), 1);
        chk("lu_pc_write", 0, 32'(pcw0), 0);
        tick();
        settle();
        chk("lu_release", 0, 32'(bb0), 0);
        chk("lu_stall_cnt", 0, 32'(sc0), 1);
        tick();
        nop(); settle(); chk("lu_fwd_b", 0, 32'(fb0), 2); tick();

        // r0 is never a producer, even for loads
        do_reset();
        issue(0, 0, 0, 0, 1, 0, 0, 0);  settle(); tick();
        issue(0, 0, 0, 0, 1, 0, 1, 0);  settle(); tick();
        issue(0, 0, 1, 0, 0, 0, 0, 0);  settle(); chk("r0_no_stall", 0, 32'(bb0), 0); tick();
        nop(); settle(); chk("r0_fwd_a", 0, 32'(fa0), 0); tick();

        // Branch behind a load: stall suppresses the flush for one cycle
        do_reset();
        issue(1, 2, 0, 0, 1, 3, 1, 0);  settle(); tick();
        issue(3, 0, 1, 0, 0, 0, 0, 1);  settle();
        chk("br_no_flush", 0, 32'(fl0), 0);
        chk("br_bubble", 0, 32'(bb0), 1);
        tick();
        settle(); chk("br_flush", 0, 32'(fl0), 1); tick();
        nop(); settle(); chk("br_flush_cnt", 0, 32'(fc0), 1); tick();

        // Hold across a pending load-use stall
        do_reset();
        issue(0, 0, 0, 0, 1, 8, 1, 0);  settle(); tick();
        issue(0, 8, 0, 1, 0, 0, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_bubble", 0, 32'(bb0), 0);
            chk("hold_pc_write", 0, 32'(pcw0), 0);
            chk("hold_stall_cnt", 0, 32'(sc0), 0);
            tick();
        end
        hold = 1'b0;
        settle(); chk("hold_rel_bubble", 0, 32'(bb0), 1); tick();
        settle(); chk("hold_one_bubble", 0, 32'(bb0), 0); chk("hold_cnt", 0, 32'(sc0), 1); tick();

        // Deep config: two stall cycles, then forward from slot 4
        do_reset();
        issue(0, 0, 0, 0, 1, 8, 1, 0);  settle(); tick();
        issue(0, 8, 0, 1, 0, 0, 0, 0);
        settle(); chk("deep_stall1", 1, 32'(bb1), 1); tick();
        settle(); chk("deep_stall2", 1, 32'(bb1), 1); tick();
        settle(); chk("deep_release", 1, 32'(bb1), 0); chk("deep_cnt", 1, 32'(sc1), 2); tick();
        nop(); settle(); chk("deep_fwd_b", 1, 32'(fb1), 3); tick();

        // Reset asserted mid-stall cancels the bubble in the same cycle
        do_reset();
        issue(0, 0, 0, 0, 1, 8, 1, 0);  settle(); tick();
        issue(0, 8, 0, 1, 0, 0, 0, 0);  settle(); tick();
        chk("mid_pending", 1, 32'(bb1), 1);
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("mid_bubble", 1, 32'(bb1), 0);
        chk("mid_pc_write", 1, 32'(pcw1), 1);
        chk("mid_stall_cnt", 1, 32'(sc1), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic over a small register window to force collisions
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
                id_valid = ($urandom_range(0, 3) != 0);
                hold = ($urandom_range(0, 7) == 0);
                settle();
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
